// File: rtl/reg_rename_file_pkg.sv
// Shared constants and types for the rename register file.
// Optional commit forwarding is enabled by defining REG_COMMIT_BYPASS_EN.
package reg_rename_file_pkg;
  localparam int RRF_REG_NUM = 32;
  localparam int RRF_ROB_W   = 4;
  localparam int RRF_REG_W   = 5;
  localparam int RRF_DATA_W  = 32;

  typedef logic [RRF_REG_W-1:0]  reg_id_t;
  typedef logic [RRF_DATA_W-1:0] data_t;

  function automatic logic is_x0(input reg_id_t r);
    return (r == '0);
  endfunction
endpackage

// File: rtl/reg_rename_file_if.sv
// Issue / ROB facing bus of the rename register file.
// master = Issue+ROB side, slave = register file.
interface reg_rename_file_if
  import reg_rename_file_pkg::*;
#(
  parameter int ROB_W = RRF_ROB_W
);
  logic             IS_sgn;
  logic             IS_rd_en;
  reg_id_t          IS_rs1;
  reg_id_t          IS_rs2;
  reg_id_t          IS_rd;
  logic [ROB_W-1:0] IS_ROB_name;
  logic             IS_rdy1;
  data_t            IS_val1;
  logic [ROB_W-1:0] IS_tag1;
  logic             IS_rdy2;
  data_t            IS_val2;
  logic [ROB_W-1:0] IS_tag2;

  logic [ROB_W-1:0] ROB_ord1;
  logic [ROB_W-1:0] ROB_ord2;
  logic             ROB_rdy1;
  data_t            ROB_val1;
  logic             ROB_rdy2;
  data_t            ROB_val2;

  logic             ROB_commit_sgn;
  reg_id_t          ROB_commit_dest;
  data_t            ROB_commit_value;
  logic [ROB_W-1:0] ROB_commit_name;
  logic             jp_wrong;

  modport master (
    output IS_sgn, IS_rd_en, IS_rs1, IS_rs2, IS_rd, IS_ROB_name,
    input  IS_rdy1, IS_val1, IS_tag1, IS_rdy2, IS_val2, IS_tag2,
    input  ROB_ord1, ROB_ord2,
    output ROB_rdy1, ROB_val1, ROB_rdy2, ROB_val2,
    output ROB_commit_sgn, ROB_commit_dest, ROB_commit_value, ROB_commit_name,
    output jp_wrong
  );

  modport slave (
    input  IS_sgn, IS_rd_en, IS_rs1, IS_rs2, IS_rd, IS_ROB_name,
    output IS_rdy1, IS_val1, IS_tag1, IS_rdy2, IS_val2, IS_tag2,
    output ROB_ord1, ROB_ord2,
    input  ROB_rdy1, ROB_val1, ROB_rdy2, ROB_val2,
    input  ROB_commit_sgn, ROB_commit_dest, ROB_commit_value, ROB_commit_name,
    input  jp_wrong
  );
endinterface

// File: rtl/reg_rename_file_resolve.sv
// reg_operand_resolve: priority resolution of one source operand into
// a ready value or the producer ROB tag.
module reg_operand_resolve
  import reg_rename_file_pkg::*;
#(
  parameter int ROB_W = RRF_ROB_W
) (
  input  reg_id_t          rs,
  input  logic             busy,
  input  data_t            reg_val,
  input  logic [ROB_W-1:0] reg_tag,
  input  logic             rob_rdy,
  input  data_t            rob_val,
  input  logic             byp_hit,
  input  data_t            byp_val,
  output logic             rdy,
  output data_t            val,
  output logic [ROB_W-1:0] tag
);
  assign tag = reg_tag;

  always_comb begin
    rdy = 1'b0;
    val = '0;
    if (is_x0(rs)) begin
      rdy = 1'b1;
    end else if (!busy) begin
      rdy = 1'b1;
      val = reg_val;
    end else if (rob_rdy) begin
      rdy = 1'b1;
      val = rob_val;
    end else if (byp_hit) begin
      rdy = 1'b1;
      val = byp_val;
    end
  end
endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with busy/tag rename state, ROB commit and flush.
// Define REG_COMMIT_BYPASS_EN to forward a same-cycle commit to issuing sources.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int REG_NUM = RRF_REG_NUM,
  parameter int ROB_W   = RRF_ROB_W
) (
  input logic                clk,
  input logic                rst,
  input logic                rdy,
  reg_rename_file_if.slave   bus
);
  data_t              regs [REG_NUM];
  logic [ROB_W-1:0]   tag  [REG_NUM];
  logic [REG_NUM-1:0] busy;

  logic  commit_wr;
  logic  rename_wr;
  logic  byp_hit1;
  logic  byp_hit2;

  assign commit_wr = bus.ROB_commit_sgn && !is_x0(bus.ROB_commit_dest);
  assign rename_wr = bus.IS_sgn && bus.IS_rd_en && !is_x0(bus.IS_rd) && !bus.jp_wrong;

`ifdef REG_COMMIT_BYPASS_EN
  assign byp_hit1 = bus.ROB_commit_sgn && (bus.ROB_commit_dest == bus.IS_rs1) &&
                    (tag[bus.IS_rs1] == bus.ROB_commit_name);
  assign byp_hit2 = bus.ROB_commit_sgn && (bus.ROB_commit_dest == bus.IS_rs2) &&
                    (tag[bus.IS_rs2] == bus.ROB_commit_name);
`else
  assign byp_hit1 = 1'b0;
  assign byp_hit2 = 1'b0;
`endif

  assign bus.ROB_ord1 = tag[bus.IS_rs1];
  assign bus.ROB_ord2 = tag[bus.IS_rs2];

  reg_operand_resolve #(.ROB_W(ROB_W)) u_res1 (
    .rs      (bus.IS_rs1),
    .busy    (busy[bus.IS_rs1]),
    .reg_val (regs[bus.IS_rs1]),
    .reg_tag (tag[bus.IS_rs1]),
    .rob_rdy (bus.ROB_rdy1),
    .rob_val (bus.ROB_val1),
    .byp_hit (byp_hit1),
    .byp_val (bus.ROB_commit_value),
    .rdy     (bus.IS_rdy1),
    .val     (bus.IS_val1),
    .tag     (bus.IS_tag1)
  );

  reg_operand_resolve #(.ROB_W(ROB_W)) u_res2 (
    .rs      (bus.IS_rs2),
    .busy    (busy[bus.IS_rs2]),
    .reg_val (regs[bus.IS_rs2]),
    .reg_tag (tag[bus.IS_rs2]),
    .rob_rdy (bus.ROB_rdy2),
    .rob_val (bus.ROB_val2),
    .byp_hit (byp_hit2),
    .byp_val (bus.ROB_commit_value),
    .rdy     (bus.IS_rdy2),
    .val     (bus.IS_val2),
    .tag     (bus.IS_tag2)
  );

  // Later assignments win: a same-cycle rename overrides the commit's busy
  // clear, and a flush overrides both.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (commit_wr) begin
        regs[bus.ROB_commit_dest] <= bus.ROB_commit_value;
        if (tag[bus.ROB_commit_dest] == bus.ROB_commit_name)
          busy[bus.ROB_commit_dest] <= 1'b0;
      end
      if (bus.jp_wrong) begin
        busy <= '0;
      end else if (rename_wr) begin
        busy[bus.IS_rd] <= 1'b1;
        tag[bus.IS_rd]  <= bus.IS_ROB_name;
      end
    end
  end
endmodule

// File: tb/tb_reg_rename_file.sv
// Directed self-checking bench for reg_rename_file.
module tb_reg_rename_file;
  import reg_rename_file_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_rename_file_if bus ();

  reg_rename_file dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    bus.IS_sgn = 0; bus.IS_rd_en = 0; bus.IS_rd = 0; bus.IS_ROB_name = 0;
    bus.ROB_rdy1 = 0; bus.ROB_val1 = 0; bus.ROB_rdy2 = 0; bus.ROB_val2 = 0;
    bus.ROB_commit_sgn = 0; bus.ROB_commit_dest = 0;
    bus.ROB_commit_value = 0; bus.ROB_commit_name = 0;
    bus.jp_wrong = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] name);
    bus.IS_sgn = 1; bus.IS_rd_en = 1; bus.IS_rd = rd; bus.IS_ROB_name = name;
    tick();
    idle();
  endtask

  initial begin
    rst = 1; rdy = 1;
    bus.IS_rs1 = 0; bus.IS_rs2 = 0;
    idle();
    tick(); tick();
    rst = 0;

    bus.IS_rs1 = 3; bus.IS_rs2 = 0; #1;
    chk("reset_rdy1", bus.IS_rdy1, 1);
    chk("reset_val1", bus.IS_val1, 0);
    chk("reset_rdy2", bus.IS_rdy2, 1);
    chk("reset_val2", bus.IS_val2, 0);
    chk("reset_tag1", bus.IS_tag1, 0);
    chk("reset_ord1", bus.ROB_ord1, 0);

    // Same-instruction read of rd sees old mapping
    bus.IS_rs1 = 5;
    bus.IS_sgn = 1; bus.IS_rd_en = 1; bus.IS_rd = 5; bus.IS_ROB_name = 7; #1;
    chk("self_read_rdy1", bus.IS_rdy1, 1);
    tick(); idle(); #1;
    chk("ren5_rdy1", bus.IS_rdy1, 0);
    chk("ren5_tag1", bus.IS_tag1, 7);
    chk("ren5_ord1", bus.ROB_ord1, 7);
    chk("ren5_val1", bus.IS_val1, 0);
    bus.ROB_rdy1 = 1; bus.ROB_val1 = 32'h1234; #1;
    chk("robq_rdy1", bus.IS_rdy1, 1);
    chk("robq_val1", bus.IS_val1, 32'h1234);
    bus.ROB_rdy1 = 0;

    // Stale commit: value written, newer rename kept
    rename(5, 2);
    rename(5, 9);
    bus.ROB_commit_sgn = 1; bus.ROB_commit_dest = 5;
    bus.ROB_commit_name = 2; bus.ROB_commit_value = 32'hAA;
    tick(); idle(); #1;
    chk("stale_rdy1", bus.IS_rdy1, 0);
    chk("stale_tag1", bus.IS_tag1, 9);
    // Matching commit clears busy
    bus.ROB_commit_sgn = 1; bus.ROB_commit_dest = 5;
    bus.ROB_commit_name = 9; bus.ROB_commit_value = 32'hCC;
    tick(); idle(); #1;
    chk("commit_rdy1", bus.IS_rdy1, 1);
    chk("commit_val1", bus.IS_val1, 32'hCC);

    // Commit and rename of x6 in the same cycle
    rename(6, 4);
    bus.ROB_commit_sgn = 1; bus.ROB_commit_dest = 6;
    bus.ROB_commit_name = 4; bus.ROB_commit_value = 32'h66;
    bus.IS_sgn = 1; bus.IS_rd_en = 1; bus.IS_rd = 6; bus.IS_ROB_name = 11;
    tick(); idle();
    bus.IS_rs2 = 6; #1;
    chk("cr6_rdy2", bus.IS_rdy2, 0);
    chk("cr6_tag2", bus.IS_tag2, 11);
    chk("cr6_ord2", bus.ROB_ord2, 11);

    // Flush with concurrent rename of x4
    rename(1, 1);
    rename(2, 2);
    rename(3, 3);
    bus.IS_rs1 = 1; #1;
    chk("pre_flush_rdy1", bus.IS_rdy1, 0);
    bus.jp_wrong = 1;
    bus.IS_sgn = 1; bus.IS_rd_en = 1; bus.IS_rd = 4; bus.IS_ROB_name = 5;
    tick(); idle();
    bus.IS_rs1 = 1; bus.IS_rs2 = 2; #1;
    chk("flush_rdy_x1", bus.IS_rdy1, 1);
    chk("flush_rdy_x2", bus.IS_rdy2, 1);
    bus.IS_rs1 = 3; bus.IS_rs2 = 4; #1;
    chk("flush_rdy_x3", bus.IS_rdy1, 1);
    chk("flush_rdy_x4", bus.IS_rdy2, 1);
    chk("flush_val_x4", bus.IS_val2, 0);
    bus.IS_rs1 = 6; #1;
    chk("flush_val_x6", bus.IS_val1, 32'h66);

    // x0 never renamed, never written
    bus.ROB_commit_sgn = 1; bus.ROB_commit_dest = 0; bus.ROB_commit_value = 32'hDEAD;
    rename(0, 6);
    bus.IS_rs1 = 0; #1;
    chk("x0_rdy1", bus.IS_rdy1, 1);
    chk("x0_val1", bus.IS_val1, 0);

    // rdy=0 holds state
    rdy = 0;
    rename(7, 6);
    rdy = 1;
    bus.IS_rs1 = 7; #1;
    chk("hold_rdy1", bus.IS_rdy1, 1);

    // Commit forwarding on x8
    rename(8, 3);
    bus.IS_rs1 = 8;
    bus.ROB_commit_sgn = 1; bus.ROB_commit_dest = 8;
    bus.ROB_commit_name = 3; bus.ROB_commit_value = 32'h55; #1;
`ifdef REG_COMMIT_BYPASS_EN
    chk("byp_rdy1", bus.IS_rdy1, 1);
    chk("byp_val1", bus.IS_val1, 32'h55);
`else
    chk("nobyp_rdy1", bus.IS_rdy1, 0);
    chk("nobyp_tag1", bus.IS_tag1, 3);
`endif
    tick(); idle(); #1;
    chk("post_commit8_rdy1", bus.IS_rdy1, 1);
    chk("post_commit8_val1", bus.IS_val1, 32'h55);

    // Reset clears values and renames
    rename(9, 12);
    rst = 1; tick(); rst = 0;
    bus.IS_rs1 = 8; bus.IS_rs2 = 9; #1;
    chk("rst2_val1", bus.IS_val1, 0);
    chk("rst2_rdy2", bus.IS_rdy2, 1);
    chk("rst2_ord2", bus.ROB_ord2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
